// File: rtl/vga_bounce_box_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_bounce_box_if
// Purpose  : Count/sync inputs and RGB/box outputs of the bouncing-box source.
// Revision : 1.0  initial release
// ============================================================================
interface vga_bounce_box_if #(
    parameter int VIDEO_WIDTH = 3
);
    logic                   i_HSync;
    logic                   i_VSync;
    logic [9:0]             i_Col_Count;
    logic [9:0]             i_Row_Count;
    logic                   i_Freeze;
    logic                   o_HSync;
    logic                   o_VSync;
    logic [VIDEO_WIDTH-1:0] o_Red_Video;
    logic [VIDEO_WIDTH-1:0] o_Grn_Video;
    logic [VIDEO_WIDTH-1:0] o_Blu_Video;
    logic [9:0]             o_Box_X;
    logic [9:0]             o_Box_Y;

    modport master (
        output i_HSync, i_VSync, i_Col_Count, i_Row_Count, i_Freeze,
        input  o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video,
               o_Box_X, o_Box_Y
    );

    modport slave (
        input  i_HSync, i_VSync, i_Col_Count, i_Row_Count, i_Freeze,
        output o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video,
               o_Box_X, o_Box_Y
    );
endinterface
`default_nettype wire

// File: rtl/vga_bounce_box.sv
`default_nettype none
// ============================================================================
// Module   : vga_bounce_box
// Purpose  : Draws a square box that bounces diagonally once per frame,
//            changing colour on every bounce; video and syncs share one register.
// Revision : 1.0  initial release
// ============================================================================
module vga_bounce_box #(
    parameter int VIDEO_WIDTH = 3,
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int BOX_SIZE    = 32,
    parameter int STEP        = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    vga_bounce_box_if.slave  bus
);
    localparam logic [10:0] c_MAX_X       = 11'(ACTIVE_COLS - BOX_SIZE);
    localparam logic [10:0] c_MAX_Y       = 11'(ACTIVE_ROWS - BOX_SIZE);
    localparam logic [10:0] c_STEP        = 11'(STEP);
    localparam logic [10:0] c_BOX         = 11'(BOX_SIZE);
    localparam logic [10:0] c_ACTIVE_COLS = 11'(ACTIVE_COLS);
    localparam logic [10:0] c_ACTIVE_ROWS = 11'(ACTIVE_ROWS);
    // Frame totals are informational only: the counters are trusted as given.
    localparam int          c_unused_totals = TOTAL_COLS + TOTAL_ROWS;

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_dx;
    logic        r_dy;
    logic [2:0]  r_color;

    logic        w_tick;
    logic        w_inside;
    logic [11:0] w_x_upd;
    logic [11:0] w_y_upd;
    logic [2:0]  w_color_next;
    logic [10:0] w_col;
    logic [10:0] w_row;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;

    // Returns {bounce, new_dir, new_pos}; 11-bit arithmetic avoids wrap-around.
    function automatic logic [11:0] axis_next(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [10:0] max_pos
    );
        logic [10:0] pos_ext;
        pos_ext = {1'b0, pos};
        if (dir) begin
            if (pos_ext + c_STEP >= max_pos)
                axis_next = {1'b1, 1'b0, max_pos[9:0]};
            else
                axis_next = {1'b0, 1'b1, pos + c_STEP[9:0]};
        end else begin
            if (pos_ext <= c_STEP)
                axis_next = {1'b1, 1'b1, 10'd0};
            else
                axis_next = {1'b0, 1'b0, pos - c_STEP[9:0]};
        end
    endfunction

    assign w_col   = {1'b0, bus.i_Col_Count};
    assign w_row   = {1'b0, bus.i_Row_Count};
    assign w_x_ext = {1'b0, r_x};
    assign w_y_ext = {1'b0, r_y};

    // First blanking line, so the position is stable for the whole visible frame.
    assign w_tick = (bus.i_Col_Count == 10'd0) && (w_row == c_ACTIVE_ROWS);

    assign w_inside = (w_col >= w_x_ext) && (w_col < w_x_ext + c_BOX) &&
                      (w_row >= w_y_ext) && (w_row < w_y_ext + c_BOX) &&
                      (w_col < c_ACTIVE_COLS) && (w_row < c_ACTIVE_ROWS);

    assign w_x_upd      = axis_next(r_x, r_dx, c_MAX_X);
    assign w_y_upd      = axis_next(r_y, r_dy, c_MAX_Y);
    assign w_color_next = (r_color == 3'd7) ? 3'd1 : r_color + 3'd1;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_x             <= 10'd0;
            r_y             <= 10'd0;
            r_dx            <= 1'b1;
            r_dy            <= 1'b1;
            r_color         <= 3'd7;
            bus.o_HSync     <= 1'b0;
            bus.o_VSync     <= 1'b0;
            bus.o_Red_Video <= '0;
            bus.o_Grn_Video <= '0;
            bus.o_Blu_Video <= '0;
            bus.o_Box_X     <= 10'd0;
            bus.o_Box_Y     <= 10'd0;
        end else begin
            bus.o_HSync     <= bus.i_HSync;
            bus.o_VSync     <= bus.i_VSync;
            bus.o_Red_Video <= {VIDEO_WIDTH{w_inside & r_color[2]}};
            bus.o_Grn_Video <= {VIDEO_WIDTH{w_inside & r_color[1]}};
            bus.o_Blu_Video <= {VIDEO_WIDTH{w_inside & r_color[0]}};
            bus.o_Box_X     <= r_x;
            bus.o_Box_Y     <= r_y;
            if (w_tick && !bus.i_Freeze) begin
                r_x  <= w_x_upd[9:0];
                r_dx <= w_x_upd[10];
                r_y  <= w_y_upd[9:0];
                r_dy <= w_y_upd[10];
                // A corner hit bounces both axes but still advances one colour.
                if (w_x_upd[11] || w_y_upd[11])
                    r_color <= w_color_next;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/vga_bounce_box.md
# vga_bounce_box

Upstream video source for the VGA output path: consumes the column/row counters and sync pulses from the sync-pulse generator and produces 3-bit-per-channel RGB video for the sync/porch stage. Draws one square box on a black background. Once per frame, during vertical blanking, it moves the box diagonally, bouncing off the active-area edges. The box colour changes on every bounce. Video and syncs leave on the same registered cycle, so they stay aligned.

## Interface

Parameters:
- VIDEO_WIDTH, 3: bits per colour channel
- TOTAL_COLS, 800: columns per line, including blanking
- TOTAL_ROWS, 525: rows per frame, including blanking
- ACTIVE_COLS, 640: visible columns
- ACTIVE_ROWS, 480: visible rows
- BOX_SIZE, 32: box edge length in pixels; must be less than ACTIVE_ROWS
- STEP, 2: pixels moved per frame on each axis; must be at least 1 and less than BOX_SIZE

Ports:
- i_Clk  in  1  pixel clock. The block has one clock; all logic is on its rising edge.
- i_Rst  in  1  reset; synchronous, active-high
- i_HSync  in  1  horizontal sync from the sync-pulse generator
- i_VSync  in  1  vertical sync from the sync-pulse generator
- i_Col_Count  in  10  current column, 0..TOTAL_COLS-1
- i_Row_Count  in  10  current row, 0..TOTAL_ROWS-1
- i_Freeze  in  1  when high, frame updates leave position, direction and colour unchanged
- o_HSync  out  1  i_HSync delayed one cycle
- o_VSync  out  1  i_VSync delayed one cycle
- o_Red_Video  out  VIDEO_WIDTH  red channel
- o_Grn_Video  out  VIDEO_WIDTH  green channel
- o_Blu_Video  out  VIDEO_WIDTH  blue channel
- o_Box_X  out  10  current box left column (for observability)
- o_Box_Y  out  10  current box top row (for observability)

## Operation

State:
- r_X, r_Y: 10-bit box position
- r_Dx, r_Dy: direction per axis, 1 = increasing
- r_Color: 3-bit colour index, always in 1..7

Reset values:
- r_X = 0, r_Y = 0, r_Dx = 1, r_Dy = 1, r_Color = 7
- All outputs 0

Frame tick:
- Fires on the single cycle where i_Col_Count == 0 and i_Row_Count == ACTIVE_ROWS.
- This is the first blanking line, so position never changes while active pixels are drawn (no tearing).
- When i_Freeze = 1 at the tick, nothing updates.

X update at the tick (MAX_X = ACTIVE_COLS - BOX_SIZE):
- r_Dx = 1 and r_X + STEP >= MAX_X: r_X <= MAX_X, r_Dx <= 0, bounce.
- r_Dx = 1 otherwise: r_X <= r_X + STEP.
- r_Dx = 0 and r_X <= STEP: r_X <= 0, r_Dx <= 1, bounce.
- r_Dx = 0 otherwise: r_X <= r_X - STEP.
- Comparisons use at least 11 bits, so there is no wrap-around.

Y update at the tick:
- Same rules as X, with MAX_Y = ACTIVE_ROWS - BOX_SIZE.

Colour on bounce:
- r_Color advances once per tick if either axis bounced; a corner hit (both axes) is still one step.
- Sequence is 1, 2, …, 7, then wraps to 1; 0 (black box) never occurs.

Pixel colour:
- "Inside" means col in [r_X, r_X+BOX_SIZE), row in [r_Y, r_Y+BOX_SIZE), col < ACTIVE_COLS and row < ACTIVE_ROWS.
- Inside: Red = all VIDEO_WIDTH bits set to r_Color[2], Grn = all set to r_Color[1], Blu = all set to r_Color[0].
- Otherwise: all channels 0. Blanking pixels are always 0.

## Timing

- Latency is 1 cycle from input counts/syncs to outputs; video and syncs share the same output register.
- Position, direction and colour registers change on the clock edge that samples the tick. Their new values appear on o_Box_X/o_Box_Y the following cycle.
- The first active pixel of the next frame uses the updated position.
- i_Rst asserted on any cycle, mid-frame or mid-line:
  - Next edge returns all state and outputs to reset values.
  - A tick coincident with reset is ignored.
  - The first cycle after release outputs the delayed inputs sampled on that release cycle.

## Test plan

1. **Reset:** hold i_Rst 3 cycles with random inputs -> all outputs 0. After release, inputs (col 0, row 0) -> one cycle later RGB = 7/7/7. Inputs (col 32, row 0) -> RGB = 0/0/0.
2. **Motion:** run one frame boundary -> o_Box_X = o_Box_Y = 2.
   - Pixels (1,1) and (34,34) are black.
   - Pixels (2,2) and (33,33) are white.
   - Pixel (700,500) is black.
3. **Bounce and colour:** run 224 ticks -> r_Y = 448, r_Dy = 0, colour 1 (RGB 0/0/7).
   - At tick 304 -> r_X = 608, r_Dx = 0, colour 2 (RGB 0/7/0).
   - Confirm the decreasing-direction bounce to 0 occurs and colour advances exactly once per bounce tick.
4. **Corner:** bench with ACTIVE_COLS = ACTIVE_ROWS = 480, same box size, run 224 ticks -> both directions flip on the same tick. Colour goes 7 -> 1 (single step).
5. **Freeze:** i_Freeze high across 3 ticks -> o_Box_X, o_Box_Y and colour unchanged. After release, the next tick advances by STEP.
6. **Sync alignment and mid-frame reset:**
   - Random sync stream -> o_HSync/o_VSync equal the inputs delayed exactly 1 cycle, outside reset.
   - After 10 ticks, assert reset at row 100 -> o_Box_X = o_Box_Y = 0 and colour white from the next frame onward.
